prescale_576_row_stream: RTL and testbench

//  Streaming x576 pre-scaler for Winograd tiles, the counterpart of the output-side /576 normalization.

---
 rtl/winograd_pkg.sv | 13 +
 rtl/sat_mul576.sv | 14 +
 rtl/prescale_576_row_stream.sv | 76 +++++++
 tb/tb_prescale_576_row_stream.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// winograd_pkg: shared Winograd tile geometry, element types and the 42-to-32-bit saturator
package winograd_pkg;
   localparam int WG_TILE_ROWS = 8;
   localparam int WG_TILE_COLS = 10;
   localparam int WG_SCALE = 576;
   typedef logic signed [31:0] wg_elem_t;
   typedef wg_elem_t wg_row_t [WG_TILE_COLS-1:0];
   typedef logic signed [41:0] wg_prod_t;
   function automatic wg_elem_t wg_sat(input wg_prod_t p);
      return (p > 42'sd2147483647) ? 32'sh7FFFFFFF :
             (p < -42'sd2147483648) ? 32'sh80000000 : p[31:0];
   endfunction
endpackage

// File: rtl/sat_mul576.sv
// sat_mul576: combinational x576 of one element as two shifts; flags a product outside 32-bit range
module sat_mul576
   import winograd_pkg::*;
(
   input  wg_elem_t x,
   output wg_prod_t p,
   output logic     sat
);
   wg_prod_t xe;
   assign xe = {{10{x[31]}}, x};
   assign p = (xe <<< 9) + (xe <<< 6);
   // in range only when bits 41..31 are all copies of the sign
   assign sat = !((&p[41:31]) || !(|p[41:31]));
endmodule

// File: rtl/prescale_576_row_stream.sv
// prescale_576_row_stream: two-stage x576 saturating row pre-scaler for 8x10 Winograd tiles
// with row index, tile-last and per-tile / sticky saturation flags.
module prescale_576_row_stream
   import winograd_pkg::*;
#(
   parameter int ROWS = WG_TILE_ROWS,
   parameter int COLS = WG_TILE_COLS,
   parameter int DW   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COLS*DW-1:0] in_row,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COLS*DW-1:0] out_row,
   output logic [2:0]        out_row_idx,
   output logic              out_last,
   output logic              out_tile_sat,
   output logic              sat_sticky,
   input  logic              sat_clear
);
   logic            en, s1_valid, out_row_sat, acc;
   logic [2:0]      cnt, s1_idx;
   logic [COLS-1:0] sat, s1_sat;
   wg_row_t         in_elems;
   wg_prod_t        prod [COLS];
   wg_prod_t        s1_prod [COLS];

   assign en = !out_valid || out_ready;
   assign in_ready = en;
   assign out_last = out_valid && (out_row_idx == 3'(ROWS-1));
   assign out_tile_sat = out_last && (acc || out_row_sat);

   for (genvar c = 0; c < COLS; c++) begin : g_mul
      assign in_elems[c] = in_row[c*DW +: DW];
      sat_mul576 u_mul (.x(in_elems[c]), .p(prod[c]), .sat(sat[c]));
   end

   // whole pipe advances together, so bubbles keep their slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         s1_valid <= 1'b0;
         s1_idx <= '0;
         s1_sat <= '0;
         for (int c = 0; c < COLS; c++) s1_prod[c] <= '0;
         out_valid <= 1'b0;
         out_row <= '0;
         out_row_idx <= '0;
         out_row_sat <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_idx <= cnt;
         s1_sat <= sat;
         for (int c = 0; c < COLS; c++) s1_prod[c] <= prod[c];
         out_valid <= s1_valid;
         out_row_idx <= s1_idx;
         out_row_sat <= |s1_sat;
         for (int c = 0; c < COLS; c++) out_row[c*DW +: DW] <= wg_sat(s1_prod[c]);
         if (in_valid) cnt <= (cnt == 3'(ROWS-1)) ? 3'd0 : cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= 1'b0;
      else if (out_valid && out_ready) acc <= out_last ? 1'b0 : (acc || out_row_sat);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_sticky <= 1'b0;
      else if (sat_clear) sat_sticky <= 1'b0;
      else if (out_valid && out_ready && out_row_sat) sat_sticky <= 1'b1;
   end
endmodule

// File: tb/tb_prescale_576_row_stream.sv
// tb_prescale_576_row_stream: directed and random rows against a queue-based saturating x576 model
module tb_prescale_576_row_stream;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, sat_clear = 0;
   logic in_ready, out_valid, out_last, out_tile_sat, sat_sticky;
   logic [319:0] in_row = '0, out_row;
   logic [2:0] out_row_idx;

   always #5 clk = ~clk;

   prescale_576_row_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
      .out_last(out_last), .out_tile_sat(out_tile_sat), .sat_sticky(sat_sticky), .sat_clear(sat_clear)
   );

   typedef struct {
      logic [319:0] row;
      logic [2:0]   idx;
      logic         last;
      logic         tsat;
      logic         rsat;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   logic [319:0] src_q[$];
   int checks = 0, failures = 0, cyc = 0, n_acc = 0;
   logic [2:0] m_idx = 0;
   logic m_acc = 0, m_sticky = 0, prev_stall = 0, lat_chk = 0, bnd_chk = 0;
   logic [319:0] prev_row = '0;

   task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [319:0] r);
      exp_t e;
      longint p;
      e.row = '0;
      e.rsat = 0;
      e.idx = 0;
      e.last = 0;
      e.tsat = 0;
      e.cyc = 0;
      for (int c = 0; c < 10; c++) begin
         p = longint'($signed(r[c*32 +: 32])) * 576;
         if (p > 64'sd2147483647) begin
            e.row[c*32 +: 32] = 32'h7FFFFFFF;
            e.rsat = 1;
         end else if (p < -64'sd2147483648) begin
            e.row[c*32 +: 32] = 32'h80000000;
            e.rsat = 1;
         end else e.row[c*32 +: 32] = p[31:0];
      end
      return e;
   endfunction

   function automatic logic [319:0] seq_row(input int r);
      logic [319:0] v;
      v = '0;
      for (int c = 0; c < 10; c++) v[c*32 +: 32] = 32'(r*10 + c);
      return v;
   endfunction

   task automatic push_tile(input int sp_row, input logic [319:0] sp);
      for (int r = 0; r < 8; r++) src_q.push_back(r == sp_row ? sp : seq_row(r));
   endtask

   task automatic cycle();
      exp_t e;
      logic hs, rs, nxt;
      #1;
      rs = 0;
      if (prev_stall) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_row", out_row, prev_row);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      hs = out_valid && out_ready;
      if (hs) begin
         if (exp_q.size() == 0) chk("spurious_out", 1, 0);
         else begin
            e = exp_q.pop_front();
            rs = e.rsat;
            chk("row", out_row, e.row);
            chk("idx", out_row_idx, e.idx);
            chk("last", out_last, e.last);
            chk("tile_sat", out_tile_sat, e.tsat);
            if (lat_chk) chk("latency", cyc - e.cyc, 2);
            if (bnd_chk && e.idx == 3) begin
               chk("bnd_pos_ok", out_row[31:0], 32'h7FFFFF80);
               chk("bnd_pos_sat", out_row[63:32], 32'h7FFFFFFF);
               chk("bnd_neg_ok", out_row[95:64], 32'h80000080);
               chk("bnd_neg_sat", out_row[127:96], 32'h80000000);
            end
         end
      end
      nxt = sat_clear ? 1'b0 : (rs ? 1'b1 : m_sticky);
      if (in_valid && in_ready) begin
         e = model(in_row);
         e.idx = m_idx;
         e.last = (m_idx == 3'd7);
         e.tsat = e.last && (m_acc || e.rsat);
         m_acc = e.last ? 1'b0 : (m_acc || e.rsat);
         m_idx = m_idx + 3'd1;
         e.cyc = cyc;
         exp_q.push_back(e);
         void'(src_q.pop_front());
         n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_row = out_row;
      @(posedge clk);
      cyc++;
      m_sticky = nxt;
      @(negedge clk);
      chk("sticky", sat_sticky, m_sticky);
   endtask

   task automatic run(input int vp, input int rp, input int stall_at, input int lim, input int budget);
      int t, a0;
      t = 0;
      a0 = n_acc;
      while ((src_q.size() > 0 || exp_q.size() > 0) && (lim < 0 || n_acc - a0 < lim)) begin
         if (t == budget) begin
            chk("timeout", 1, 0);
            break;
         end
         in_valid = src_q.size() > 0 && $urandom_range(99) < vp;
         in_row = src_q.size() > 0 ? src_q[0] : '0;
         out_ready = (t >= stall_at && t < stall_at + 5) ? 1'b0 : ($urandom_range(99) < rp);
         cycle();
         t++;
      end
      in_valid = 0;
      out_ready = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [319:0] r;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_row", out_row, 0);
      chk("rst_idx", out_row_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_tile_sat", out_tile_sat, 0);
      chk("rst_sticky", sat_sticky, 0);
      rst_n = 1;
      @(negedge clk);

      // single tile, full throughput, latency checked
      lat_chk = 1;
      push_tile(-1, '0);
      run(100, 100, -10, -1, 100);
      lat_chk = 0;

      // saturation bounds in row 3, then a tile that stays just inside range
      bnd_chk = 1;
      r = '0;
      r[31:0] = 32'd3728270;
      r[63:32] = 32'd3728271;
      r[95:64] = -32'sd3728270;
      r[127:96] = -32'sd3728271;
      push_tile(3, r);
      run(100, 100, -10, -1, 100);
      bnd_chk = 0;
      chk("sticky_set", sat_sticky, 1);
      r = '0;
      r[31:0] = 32'd3728270;
      r[63:32] = -32'sd3728270;
      push_tile(2, r);
      run(100, 100, -10, -1, 100);

      // backpressure mid-tile
      push_tile(-1, '0);
      run(100, 100, 4, -1, 100);

      // back-to-back tiles, only the first saturating, then clear
      r = '0;
      r[255:224] = 32'h7FFFFFFF;
      push_tile(5, r);
      push_tile(-1, '0);
      run(100, 100, -10, -1, 100);
      sat_clear = 1;
      cycle();
      sat_clear = 0;
      chk("clear", sat_sticky, 0);

      // reset after row 4 is accepted
      r = '0;
      r[31:0] = 32'h80000000;
      push_tile(1, r);
      run(100, 100, -10, 5, 50);
      rst_n = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_row", out_row, 0);
      chk("arst_idx", out_row_idx, 0);
      chk("arst_sticky", sat_sticky, 0);
      chk("arst_ready", in_ready, 1);
      src_q.delete();
      exp_q.delete();
      m_idx = 0;
      m_acc = 0;
      m_sticky = 0;
      prev_stall = 0;
      @(negedge clk);
      rst_n = 1;
      push_tile(-1, '0);
      run(100, 100, -10, -1, 100);

      // random traffic
      for (int i = 0; i < 1000; i++) begin
         for (int c = 0; c < 10; c++) begin
            case ($urandom_range(2))
               0: r[c*32 +: 32] = 32'($signed($urandom_range(2000)) - 1000);
               1: r[c*32 +: 32] = $urandom_range(1) ? 32'(3728268 + $urandom_range(6))
                                                    : 32'(-3728268 - $signed($urandom_range(6)));
               default: r[c*32 +: 32] = $urandom;
            endcase
         end
         src_q.push_back(r);
      end
      run(70, 70, -10, -1, 20000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
